// File: rtl/pc_sequencer.sv
// Fetch-address sequencer for the RV32I core.
// It handles boot, sequential advance, redirects, traps and halt/resume.
module pc_sequencer #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = 10'h3F0,
  parameter int                CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              trap_req,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] bad_addr,
  output logic [1:0]        trap_cause,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_EXT  = 2'd1;
  localparam logic [1:0] CAUSE_MIS  = 2'd2;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] bad_q, bad_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              misaligned;
  logic              accept;

  assign pc_inc     = pc_q + ADDR_W'(4);
  assign misaligned = redirect_target[1:0] != 2'b00;
  assign accept     = (state_q == RUN) && imem_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    bad_d   = bad_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    // Counts the fetch even when the same edge redirects or traps
    if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (trap_req) begin
          pc_d    = TRAP_VEC;
          epc_d   = pc_q;
          cause_d = CAUSE_EXT;
        end else if (redirect_valid && misaligned) begin
          pc_d    = TRAP_VEC;
          epc_d   = pc_q;
          bad_d   = redirect_target;
          cause_d = CAUSE_MIS;
        end else if (redirect_valid) begin
          pc_d = redirect_target;
        end else if (halt_req) begin
          state_d = HALT;
        end else if (imem_ready) begin
          pc_d = pc_inc;
        end
      end
      HALT: begin
        if (trap_req) begin
          pc_d    = TRAP_VEC;
          epc_d   = pc_q;
          cause_d = CAUSE_EXT;
          state_d = RUN;
        end else if (resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      bad_q   <= '0;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      bad_q   <= bad_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_inc;
  assign fetch_valid = state_q == RUN;
  assign epc         = epc_q;
  assign bad_addr    = bad_q;
  assign trap_cause  = cause_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations
// plus randomized traffic against a behavioural model.
module tb_pc_sequencer;
  localparam int AW = 10;
  localparam int CW = 32;
  localparam int TV = 'h3F0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_target = '0;
  logic          trap_req = 1'b0;
  logic          halt_req = 1'b0;
  logic          resume = 1'b0;
  logic          imem_ready = 1'b0;
  logic [AW-1:0] pc, pc_plus4, epc, bad_addr;
  logic          fetch_valid;
  logic [1:0]    trap_cause;
  logic [CW-1:0] fetch_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W(AW),
    .RESET_VEC(10'h000),
    .TRAP_VEC(10'h3F0),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .trap_req(trap_req),
    .halt_req(halt_req),
    .resume(resume),
    .imem_ready(imem_ready),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid),
    .epc(epc),
    .bad_addr(bad_addr),
    .trap_cause(trap_cause),
    .fetch_count(fetch_count)
  );

  // Reference model: mode 0 = booting, 1 = fetching, 2 = halted
  int          m_pc, m_epc, m_bad, m_cause, m_mode;
  int unsigned m_cnt;
  bit          m_live = 0;

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic take_trap(input int cause);
    m_epc   = m_pc;
    m_pc    = TV;
    m_cause = cause;
  endtask

  task automatic model_step();
    int tgt;
    tgt = int'(redirect_target);
    if (reset) begin
      m_pc = 0; m_epc = 0; m_bad = 0;
      m_cause = 0; m_cnt = 0; m_mode = 0;
      return;
    end
    if (m_mode == 1 && imem_ready) m_cnt++;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (trap_req) take_trap(1);
      else if (redirect_valid && (tgt % 4) != 0) begin
        m_bad = tgt;
        take_trap(2);
      end
      else if (redirect_valid) m_pc = tgt;
      else if (halt_req) m_mode = 2;
      else if (imem_ready) m_pc = (m_pc + 4) % 1024;
    end else begin
      if (trap_req) begin
        take_trap(1);
        m_mode = 1;
      end else if (resume) m_mode = 1;
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, (m_pc + 4) % 1024);
      check("fetch_valid", fetch_valid, m_mode == 1);
      check("epc", epc, m_epc);
      check("bad_addr", bad_addr, m_bad);
      check("trap_cause", trap_cause, m_cause);
      check("fetch_count", fetch_count, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    m_live = 1;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    redirect_valid = 0; trap_req = 0;
    halt_req = 0; resume = 0;
  endtask

  task automatic redir(input int tgt);
    redirect_valid  = 1;
    redirect_target = AW'(tgt);
    tick();
    redirect_valid = 0;
  endtask

  initial begin
    // Reset, boot, advance
    reset = 1; idle(); imem_ready = 0;
    tick(); tick();
    reset = 0; imem_ready = 1;
    check("rst_pc", pc, 0);
    check("rst_fv", fetch_valid, 0);
    check("rst_cause", trap_cause, 0);
    check("rst_cnt", fetch_count, 0);
    tick();
    check("boot_pc0", pc, 0);
    check("boot_fv", fetch_valid, 1);
    check("boot_cnt0", fetch_count, 0);
    tick(); check("adv_pc4", pc, 4);
    tick(); check("adv_pc8", pc, 8);
    tick(); check("adv_pc12", pc, 12);
    check("adv_cnt3", fetch_count, 3);

    // Stall then wrap
    redir('h3F8);
    imem_ready = 0;
    repeat (3) begin
      tick();
      check("stall_pc", pc, 'h3F8);
      check("stall_cnt", fetch_count, 4);
    end
    imem_ready = 1;
    tick(); check("wrap_pc3fc", pc, 'h3FC);
    tick(); check("wrap_pc0", pc, 0);
    check("wrap_plus4", pc_plus4, 4);

    // Redirects with memory stalled
    redir('h010);
    imem_ready = 0;
    redir('h100);
    check("redir_pc", pc, 'h100);
    redir('h010);
    redir('h102);
    check("mis_pc", pc, 'h3F0);
    check("mis_epc", epc, 'h010);
    check("mis_bad", bad_addr, 'h102);
    check("mis_cause", trap_cause, 2);

    // Trap, redirect and halt together
    redir('h020);
    trap_req = 1; halt_req = 1;
    redir('h200);
    idle();
    check("sim_pc", pc, 'h3F0);
    check("sim_epc", epc, 'h020);
    check("sim_cause", trap_cause, 1);
    check("sim_fv", fetch_valid, 1);

    // Halt ignores redirects until resume
    redir('h040);
    halt_req = 1; tick(); halt_req = 0;
    redirect_valid = 1; redirect_target = AW'('h080);
    imem_ready = 1;
    repeat (5) begin
      tick();
      check("halt_pc", pc, 'h040);
      check("halt_fv", fetch_valid, 0);
    end
    redirect_valid = 0; resume = 1;
    tick(); resume = 0;
    check("resume_pc", pc, 'h040);
    check("resume_fv", fetch_valid, 1);

    // Reset while halted after a misaligned trap
    imem_ready = 0;
    redir('h041);
    halt_req = 1; tick(); halt_req = 0;
    check("pre_rst_cause", trap_cause, 2);
    check("pre_rst_fv", fetch_valid, 0);
    reset = 1; tick(); reset = 0;
    check("mid_rst_pc", pc, 0);
    check("mid_rst_cause", trap_cause, 0);
    check("mid_rst_cnt", fetch_count, 0);
    check("mid_rst_fv", fetch_valid, 0);
    tick();
    check("mid_rst_run", fetch_valid, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      redirect_valid = $urandom_range(99) < 15;
      redirect_target = AW'($urandom);
      if ($urandom_range(1) == 1) redirect_target[1:0] = 2'b00;
      trap_req   = $urandom_range(99) < 5;
      halt_req   = $urandom_range(99) < 6;
      resume     = $urandom_range(99) < 20;
      imem_ready = $urandom_range(99) < 70;
      reset      = $urandom_range(999) < 8;
      tick();
    end
    reset = 0; idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle RV32I core: holds the fetch address, advances it by 4 on each accepted fetch, and applies branch/jump redirects, external traps, misaligned-target traps and halt/resume. Sits between the branch/jump resolution logic and instruction memory. It adds a fetch handshake, a boot state, a trap path with saved PC and an accepted-fetch counter.

## Interface
Parameters:
- `ADDR_W`, 10: PC width in bits (byte address).
- `RESET_VEC`, 0: PC value loaded by reset.
- `TRAP_VEC`, 10'h3F0: PC value loaded on any trap; must be 4-byte aligned.
- `CNT_W`, 32: width of the accepted-fetch counter.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `redirect_valid` in 1: branch taken or jump resolved this cycle.
- `redirect_target` in ADDR_W: target address for the redirect.
- `trap_req` in 1: external trap request.
- `halt_req` in 1: request to stop fetching.
- `resume` in 1: leave HALT.
- `imem_ready` in 1: instruction memory accepts the current fetch.
- `pc` out ADDR_W: current fetch address.
- `pc_plus4` out ADDR_W: `pc + 4` modulo 2^ADDR_W, combinational from `pc`.
- `fetch_valid` out 1: `pc` is a valid fetch request.
- `epc` out ADDR_W: PC at the most recent trap.
- `bad_addr` out ADDR_W: offending target of the most recent misaligned trap.
- `trap_cause` out 2: 0 none, 1 external, 2 misaligned target. Held until the next trap.
- `fetch_count` out CNT_W: number of accepted fetches.

## Operation
- Reset: `pc`=RESET_VEC, state BOOT, `epc`=0, `bad_addr`=0, `trap_cause`=0, `fetch_count`=0, `fetch_valid`=0.
- States:
  - BOOT: `fetch_valid`=0. Always goes to RUN on the next cycle. All requests in BOOT are ignored.
  - RUN: `fetch_valid`=1.
  - HALT: `fetch_valid`=0 and `pc` held.
- Priority in RUN, highest first:
  1. `trap_req`: `pc`<=TRAP_VEC, `epc`<=`pc`, `trap_cause`<=1.
  2. `redirect_valid` with `redirect_target[1:0]`!=0: `pc`<=TRAP_VEC, `epc`<=`pc`, `bad_addr`<=`redirect_target`, `trap_cause`<=2.
  3. `redirect_valid` (aligned): `pc`<=`redirect_target`.
  4. `halt_req`: go to HALT, `pc` held.
  5. `imem_ready`: `pc`<=`pc_plus4`.
  6. Otherwise: `pc` held (stall).
- Redirects in RUN take effect whether or not `imem_ready` is asserted.
- In HALT:
  - `trap_req` behaves as in RUN and returns to RUN.
  - Else `resume` returns to RUN with `pc` unchanged.
  - `redirect_valid`, `halt_req` and `imem_ready` are ignored.
- `fetch_count` increments by 1 on each cycle with `fetch_valid` && `imem_ready`, including the cycle of a redirect or trap. It wraps modulo 2^CNT_W.
- Address arithmetic is unsigned modulo 2^ADDR_W: `pc`=2^ADDR_W-4 advances to 0.
- `redirect_target` bits above ADDR_W do not exist; the core truncates before driving this block.
- Reset wins over every other input on the same edge. Reset in any state, including mid-trap, returns to the reset values.

## Timing
- All outputs except `pc_plus4` are registered. Every decision on edge N is visible after edge N.
- Redirect, trap and halt latency is 1 cycle, with no bubble: the new `pc` is presented with `fetch_valid`=1 in the cycle after the request (HALT excepted).
- First valid fetch is in the 2nd cycle after `reset` deasserts: one BOOT cycle, then RUN at RESET_VEC.
- `resume` latency: `fetch_valid` rises 1 cycle after `resume`.
- Requests are level-sampled with no internal queuing. A request not held across the sampling edge is lost.

## Test plan
- **Reset/boot/advance:** reset 2 cycles, then `imem_ready`=1 -> `fetch_valid`=0 for one cycle, then `pc` = 0, 4, 8, 12; `fetch_count` = 0, 1, 2, 3.
- **Stall and wrap:** `pc`=0x3F8, `imem_ready` low 3 cycles, then high -> `pc` holds 0x3F8, then 0x3FC, 0x000; `fetch_count` unchanged during the stall.
- **Redirect:** at `pc`=0x010, `redirect_valid`=1, target 0x100, `imem_ready`=0 -> next `pc`=0x100. Target 0x102 -> `pc`=0x3F0, `epc`=0x010, `bad_addr`=0x102, `trap_cause`=2.
- **Simultaneous events:** `trap_req`, `redirect_valid` (target 0x200) and `halt_req` in one cycle at `pc`=0x020 -> `pc`=0x3F0, `epc`=0x020, `trap_cause`=1, state RUN.
- **Halt/resume:** `halt_req` at `pc`=0x040 -> `fetch_valid`=0, `pc` stays 0x040 for 5 cycles despite a redirect to 0x080. Then `resume` -> `fetch_valid`=1 at `pc`=0x040.
- **Reset mid-operation:** assert `reset` in HALT with `trap_cause`=2 -> after the edge `pc`=RESET_VEC, `trap_cause`=0, `fetch_count`=0, BOOT then RUN.
